aes_ctrl: RTL and testbench

- Top-level sequencer for the AES-128 encryption core.
- Drives the key-expansion generator through its init/ready handshake and records when a valid key schedule exists.
- Steps the round datapath through the initial AddRoundKey and rounds 1..10, presenting the round index to both the datapath and the key-schedule read port.
- Owns the select of the single shared 32-bit S-box: during key expansion it belongs to the key generator; during SubBytes it belongs to the round datapath, one column per cycle.

---
 rtl/aes_pkg.sv | 30 +++
 rtl/aes_ctrl.sv | 170 +++++++++++++++++
 tb/tb_aes_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared types and constants for the AES-128 control slice:
//            controller state encoding, default round/column counts and the
//            S-box ownership encodings.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

   // Controller states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_KEYEXP = 3'd1,
      ST_LOAD   = 3'd2,
      ST_SUB    = 3'd3,
      ST_MIX    = 3'd4,
      ST_DONE   = 3'd5
   } aes_state_t;

   // AES-128 defaults
   localparam int NR_DEF         = 10;
   localparam int SUB_CYCLES_DEF = 4;

   // Owner of the single shared 32-bit S-box
   localparam logic SBOX_KEYGEN = 1'b0;
   localparam logic SBOX_ROUND  = 1'b1;

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_ctrl
// Purpose  : Top-level sequencer for the AES-128 core. Handshakes the key
//            expansion generator, walks the round datapath through the
//            initial AddRoundKey plus NR rounds (SUB_CYCLES S-box columns
//            followed by one commit step per round), and arbitrates the
//            shared S-box between key generator and round datapath.
//            Every output is registered or decoded from registered state.
// Revision : 1.0 - initial release
// ============================================================================
module aes_ctrl
   import aes_pkg::*;
#(
   parameter int NR         = NR_DEF,          // 1..15
   parameter int SUB_CYCLES = SUB_CYCLES_DEF   // 1..4
) (
   input  logic       clk,
   input  logic       reset,          // asynchronous, active-low
   input  logic       key_init_i,
   input  logic       start_i,
   output logic       busy_o,
   output logic       key_valid_o,
   output logic       done_o,
   output logic       start_err_o,
   output logic       kg_init_o,
   input  logic       kg_ready_i,
   output logic [3:0] kg_round_o,
   output logic       rnd_load_o,
   output logic       rnd_sub_o,
   output logic [1:0] rnd_col_o,
   output logic       rnd_step_o,
   output logic       rnd_final_o,
   output logic       sbox_sel_o
);

   // Terminal counter values sized to the counter registers
   localparam logic [3:0] R_LAST = 4'(NR);
   localparam logic [1:0] C_LAST = 2'(SUB_CYCLES - 1);

   aes_state_t state_q, state_d;
   logic [3:0] r_q, r_d;                  // round index 0..NR
   logic [1:0] c_q, c_d;                  // column index 0..SUB_CYCLES-1
   logic       seen_low_q, seen_low_d;    // kg_ready observed low this expansion
   logic       key_valid_q, key_valid_d;
   logic       kg_init_q, kg_init_d;
   logic       start_err_q, start_err_d;

   // State, counters and registered pulse outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         r_q         <= 4'd0;
         c_q         <= 2'd0;
         seen_low_q  <= 1'b0;
         key_valid_q <= 1'b0;
         kg_init_q   <= 1'b0;
         start_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         c_q         <= c_d;
         seen_low_q  <= seen_low_d;
         key_valid_q <= key_valid_d;
         kg_init_q   <= kg_init_d;
         start_err_q <= start_err_d;
      end
   end

   // Next-state, counter sequencing and output decode
   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      c_d         = c_q;
      seen_low_d  = seen_low_q;
      key_valid_d = key_valid_q;
      kg_init_d   = 1'b0;
      start_err_d = 1'b0;

      busy_o      = (state_q != ST_IDLE);
      key_valid_o = key_valid_q;
      done_o      = (state_q == ST_DONE);
      start_err_o = start_err_q;
      kg_init_o   = kg_init_q;
      kg_round_o  = 4'd0;
      rnd_load_o  = 1'b0;
      rnd_sub_o   = 1'b0;
      rnd_col_o   = 2'd0;
      rnd_step_o  = 1'b0;
      rnd_final_o = 1'b0;
      sbox_sel_o  = SBOX_KEYGEN;

      case (state_q)
         ST_IDLE: begin
            // Counters parked at zero so LOAD presents round key 0
            r_d = 4'd0;
            c_d = 2'd0;
            if (key_init_i) begin
               // key_init has priority; a simultaneous start is dropped
               kg_init_d   = 1'b1;
               key_valid_d = 1'b0;
               seen_low_d  = 1'b0;
               state_d     = ST_KEYEXP;
            end else if (start_i) begin
               if (key_valid_q) begin
                  state_d = ST_LOAD;
               end else begin
                  start_err_d = 1'b1;
               end
            end
         end

         ST_KEYEXP: begin
            // A ready still high from the previous expansion is not trusted
            // until the generator has been seen to drop it.
            if (!kg_ready_i) begin
               seen_low_d = 1'b1;
            end else if (seen_low_q) begin
               key_valid_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end

         ST_LOAD: begin
            rnd_load_o = 1'b1;
            kg_round_o = r_q;
            r_d        = 4'd1;
            c_d        = 2'd0;
            state_d    = ST_SUB;
         end

         ST_SUB: begin
            rnd_sub_o  = 1'b1;
            rnd_col_o  = c_q;
            kg_round_o = r_q;
            sbox_sel_o = SBOX_ROUND;
            if (c_q == C_LAST) begin
               state_d = ST_MIX;
            end else begin
               c_d = c_q + 2'd1;
            end
         end

         ST_MIX: begin
            rnd_step_o  = 1'b1;
            rnd_final_o = (r_q == R_LAST);
            kg_round_o  = r_q;
            if (r_q == R_LAST) begin
               state_d = ST_DONE;
            end else begin
               r_d     = r_q + 4'd1;
               c_d     = 2'd0;
               state_d = ST_SUB;
            end
         end

         ST_DONE: begin
            r_d     = 4'd0;
            c_d     = 2'd0;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule : aes_ctrl
`default_nettype wire

// File: tb/tb_aes_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_ctrl
// Purpose  : Directed self-checking bench for the AES-128 controller:
//            reset values, rejected start, key expansion handshake, full
//            encryption timeline, request collisions and mid-run reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       key_init;
   logic       start;
   logic       kg_ready;
   logic       busy, key_valid, done, start_err, kg_init;
   logic [3:0] kg_round;
   logic       rnd_load, rnd_sub, rnd_step, rnd_final, sbox_sel;
   logic [1:0] rnd_col;

   int checks   = 0;
   int failures = 0;

   aes_ctrl #(.NR(10), .SUB_CYCLES(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .key_init_i  (key_init),
      .start_i     (start),
      .busy_o      (busy),
      .key_valid_o (key_valid),
      .done_o      (done),
      .start_err_o (start_err),
      .kg_init_o   (kg_init),
      .kg_ready_i  (kg_ready),
      .kg_round_o  (kg_round),
      .rnd_load_o  (rnd_load),
      .rnd_sub_o   (rnd_sub),
      .rnd_col_o   (rnd_col),
      .rnd_step_o  (rnd_step),
      .rnd_final_o (rnd_final),
      .sbox_sel_o  (sbox_sel)
   );

   always #5 clk = ~clk;

   // Advance one clock and settle just after the active edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Observed outputs packed: busy,kv,done,serr,kginit,round[4],load,sub,col[2],step,final,sbox
   function automatic logic [15:0] obs();
      return {busy, key_valid, done, start_err, kg_init, kg_round,
              rnd_load, rnd_sub, rnd_col, rnd_step, rnd_final, sbox_sel};
   endfunction

   function automatic logic [15:0] mk(input logic b, input logic kv, input logic d,
                                      input logic se, input logic ki, input logic [3:0] kr,
                                      input logic ld, input logic sb, input logic [1:0] col,
                                      input logic st, input logic fn, input logic sx);
      return {b, kv, d, se, ki, kr, ld, sb, col, st, fn, sx};
   endfunction

   task automatic test_reset();
      reset    = 1'b0;
      key_init = 1'b0;
      start    = 1'b0;
      kg_ready = 1'b1;
      #3;
      checks++;
      if (obs() !== 16'h0000) begin
         failures++;
         $display("FAIL reset_values: got %h expected %h", obs(), 16'h0000);
      end
      tick();
      tick();
      @(negedge clk);
      reset = 1'b1;
      tick();
      checks++;
      if (obs() !== 16'h0000) begin
         failures++;
         $display("FAIL idle_after_reset: got %h expected %h", obs(), 16'h0000);
      end
   endtask

   task automatic test_start_no_key();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (obs() !== mk(0,0,0,1,0,4'd0,0,0,2'd0,0,0,0)) begin
         failures++;
         $display("FAIL start_err_pulse: got %h expected %h", obs(), mk(0,0,0,1,0,4'd0,0,0,2'd0,0,0,0));
      end
      tick();
      checks++;
      if (obs() !== 16'h0000) begin
         failures++;
         $display("FAIL start_err_single: got %h expected %h", obs(), 16'h0000);
      end
   endtask

   task automatic test_keyexp();
      int kginit_cnt;
      int sbox_cnt;
      int idle_cnt;
      kginit_cnt = 0;
      sbox_cnt   = 0;
      idle_cnt   = 0;
      kg_ready   = 1'b1;
      key_init   = 1'b1;
      tick();
      key_init = 1'b0;
      checks++;
      if (obs() !== mk(1,0,0,0,1,4'd0,0,0,2'd0,0,0,0)) begin
         failures++;
         $display("FAIL keyexp_entry: got %h expected %h", obs(), mk(1,0,0,0,1,4'd0,0,0,2'd0,0,0,0));
      end
      // Stale ready stays high for two more cycles, then low for 11
      for (int i = 0; i < 13; i++) begin
         if (i >= 2) kg_ready = 1'b0;
         tick();
         if (kg_init)   kginit_cnt++;
         if (sbox_sel)  sbox_cnt++;
         if (!busy)     idle_cnt++;
      end
      kg_ready = 1'b1;
      checks++;
      if (key_valid !== 1'b0 || busy !== 1'b1 || idle_cnt != 0) begin
         failures++;
         $display("FAIL keyexp_hold: got kv=%b busy=%b idle_cycles=%0d expected kv=0 busy=1 idle_cycles=0",
                  key_valid, busy, idle_cnt);
      end
      tick();
      checks++;
      if (key_valid !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL keyexp_complete: got kv=%b busy=%b expected kv=1 busy=0", key_valid, busy);
      end
      checks++;
      if (kginit_cnt != 0 || sbox_cnt != 0) begin
         failures++;
         $display("FAIL keyexp_pulses: got extra_kg_init=%0d sbox_round=%0d expected 0 and 0",
                  kginit_cnt, sbox_cnt);
      end
   endtask

   task automatic test_encrypt();
      int         sub_cnt;
      int         step_cnt;
      int         final_cnt;
      int         done_cyc;
      int         k;
      int         p;
      logic [3:0] er;
      logic [15:0] ev;
      sub_cnt   = 0;
      step_cnt  = 0;
      final_cnt = 0;
      done_cyc  = -1;
      kg_ready  = 1'b1;
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int cyc = 1; cyc <= 53; cyc++) begin
         if (cyc == 1) begin
            ev = mk(1,1,0,0,0,4'd0,1,0,2'd0,0,0,0);
         end else if (cyc <= 51) begin
            k  = cyc - 2;
            er = 4'(k / 5 + 1);
            p  = k % 5;
            if (p < 4) ev = mk(1,1,0,0,0,er,0,1,2'(p),0,0,1);
            else       ev = mk(1,1,0,0,0,er,0,0,2'd0,1,(er == 4'd10),0);
         end else if (cyc == 52) begin
            ev = mk(1,1,1,0,0,4'd0,0,0,2'd0,0,0,0);
         end else begin
            ev = mk(0,1,0,0,0,4'd0,0,0,2'd0,0,0,0);
         end
         checks++;
         if (obs() !== ev) begin
            failures++;
            $display("FAIL encrypt_cycle_T+%0d: got %h expected %h", cyc, obs(), ev);
         end
         if (rnd_sub)   sub_cnt++;
         if (rnd_step)  step_cnt++;
         if (rnd_final) final_cnt++;
         if (done)      done_cyc = cyc;
         // Requests while busy must be ignored
         start    = (cyc == 10);
         key_init = (cyc == 20);
         tick();
      end
      start    = 1'b0;
      key_init = 1'b0;
      checks++;
      if (sub_cnt != 40 || step_cnt != 10 || final_cnt != 1 || done_cyc != 52) begin
         failures++;
         $display("FAIL encrypt_totals: got sub=%0d step=%0d final=%0d done_at=%0d expected 40 10 1 52",
                  sub_cnt, step_cnt, final_cnt, done_cyc);
      end
   endtask

   task automatic test_collision();
      kg_ready = 1'b1;
      key_init = 1'b1;
      start    = 1'b1;
      tick();
      key_init = 1'b0;
      start    = 1'b0;
      checks++;
      if (obs() !== mk(1,0,0,0,1,4'd0,0,0,2'd0,0,0,0)) begin
         failures++;
         $display("FAIL collision_keyinit_wins: got %h expected %h", obs(), mk(1,0,0,0,1,4'd0,0,0,2'd0,0,0,0));
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (obs() !== mk(1,0,0,0,0,4'd0,0,0,2'd0,0,0,0)) begin
         failures++;
         $display("FAIL start_in_keyexp: got %h expected %h", obs(), mk(1,0,0,0,0,4'd0,0,0,2'd0,0,0,0));
      end
      kg_ready = 1'b0;
      tick();
      kg_ready = 1'b1;
      tick();
      checks++;
      if (key_valid !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL collision_keyexp_done: got kv=%b busy=%b expected kv=1 busy=0", key_valid, busy);
      end
      tick();
      checks++;
      if (obs() !== mk(0,1,0,0,0,4'd0,0,0,2'd0,0,0,0)) begin
         failures++;
         $display("FAIL collision_no_queue: got %h expected %h", obs(), mk(0,1,0,0,0,4'd0,0,0,2'd0,0,0,0));
      end
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (21) tick();
      checks++;
      if (obs() !== mk(1,1,0,0,0,4'd5,0,1,2'd0,0,0,1)) begin
         failures++;
         $display("FAIL round5_sub: got %h expected %h", obs(), mk(1,1,0,0,0,4'd5,0,1,2'd0,0,0,1));
      end
      reset = 1'b0;
      #1;
      checks++;
      if (obs() !== 16'h0000) begin
         failures++;
         $display("FAIL async_reset_mid: got %h expected %h", obs(), 16'h0000);
      end
      @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (obs() !== mk(0,0,0,1,0,4'd0,0,0,2'd0,0,0,0)) begin
         failures++;
         $display("FAIL start_after_reset: got %h expected %h", obs(), mk(0,0,0,1,0,4'd0,0,0,2'd0,0,0,0));
      end
   endtask

   initial begin
      test_reset();
      test_start_no_key();
      test_keyexp();
      test_encrypt();
      test_collision();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_aes_ctrl
`default_nettype wire
